poker_game_ctrl: RTL and testbench

//  Game sequencer for the video-poker datapath. Takes coin/bet/deal/hold/draw inputs and fetches cards

---
 rtl/poker_pkg.sv | 59 +++++
 rtl/poker_payout_lut.sv | 12 +
 rtl/poker_game_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_poker_game_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// Shared definitions for the video-poker game sequencer: state codes, hand values,
// payout multipliers and slot-scan helper.
package poker_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_DEAL    = 3'd1;
   localparam state_t ST_HOLD    = 3'd2;
   localparam state_t ST_DRAW    = 3'd3;
   localparam state_t ST_RESOLVE = 3'd4;
   localparam state_t ST_PAYOUT  = 3'd5;

   localparam logic [3:0] HV_NONE     = 4'd0;
   localparam logic [3:0] HV_JACKS    = 4'd1;
   localparam logic [3:0] HV_TWO_PAIR = 4'd2;
   localparam logic [3:0] HV_TRIPS    = 4'd3;
   localparam logic [3:0] HV_STRAIGHT = 4'd4;
   localparam logic [3:0] HV_FLUSH    = 4'd5;
   localparam logic [3:0] HV_FULL     = 4'd6;
   localparam logic [3:0] HV_QUADS    = 4'd7;
   localparam logic [3:0] HV_STR_FL   = 4'd8;
   localparam logic [3:0] HV_ROYAL    = 4'd9;

   localparam int unsigned NUM_SLOTS = 5;
   localparam logic [2:0]  NO_SLOT   = 3'd5;

   function automatic logic [15:0] payout_mult(input logic [3:0] v);
      case (v)
         HV_NONE:     return 16'd0;
         HV_JACKS:    return 16'd1;
         HV_TWO_PAIR: return 16'd2;
         HV_TRIPS:    return 16'd3;
         HV_STRAIGHT: return 16'd4;
         HV_FLUSH:    return 16'd6;
         HV_FULL:     return 16'd9;
         HV_QUADS:    return 16'd25;
         HV_STR_FL:   return 16'd50;
         HV_ROYAL:    return 16'd250;
         default:     return 16'd0;
      endcase
   endfunction

   // Lowest slot at or above start whose hold bit is clear; NO_SLOT if none remain.
   function automatic logic [2:0] first_unheld(input logic [4:0] mask, input logic [2:0] start);
      logic [2:0] r;
      logic       found;
      r     = NO_SLOT;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!found && (3'(i) >= start) && !mask[i]) begin
            r     = 3'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/poker_payout_lut.sv
// Combinational payout: hand value multiplier times bet.
module poker_payout_lut
   import poker_pkg::*;
(
   input  logic [3:0]  value_i,
   input  logic [2:0]  bet_i,
   output logic [15:0] win_o
);

   always_comb win_o = payout_mult(value_i) * {13'd0, bet_i};

endmodule

// File: rtl/poker_game_ctrl.sv
// Video-poker game sequencer: deck fetch handshake, 5-card hand registers,
// resolver handshake, payout and credit/bet bookkeeping.
module poker_game_ctrl
   import poker_pkg::*;
#(
   parameter int unsigned CREDIT_W = 16,
   parameter int unsigned MAX_BET  = 5
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                coin,
   input  logic                bet_btn,
   input  logic                deal_btn,
   input  logic [4:0]          hold,
   input  logic                draw_btn,
   output logic                card_req,
   input  logic                card_ack,
   input  logic [3:0]          card_rank,
   input  logic [1:0]          card_suit,
   output logic [3:0]          rank0,
   output logic [3:0]          rank1,
   output logic [3:0]          rank2,
   output logic [3:0]          rank3,
   output logic [3:0]          rank4,
   output logic [1:0]          suit0,
   output logic [1:0]          suit1,
   output logic [1:0]          suit2,
   output logic [1:0]          suit3,
   output logic [1:0]          suit4,
   output logic                resolve,
   input  logic                resolved,
   input  logic [3:0]          value,
   output logic [CREDIT_W-1:0] credits,
   output logic [2:0]          bet,
   output logic [15:0]         win,
   output logic [2:0]          state
);

   localparam int unsigned     SUM_W    = ((CREDIT_W > 16) ? CREDIT_W : 16) + 2;
   localparam logic [SUM_W-1:0] CRED_MAX = SUM_W'({CREDIT_W{1'b1}});
   localparam logic [2:0]      BET_MAX  = 3'(MAX_BET);

   state_t              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [4:0]          hold_q, hold_d;
   logic                req_q, req_d;
   logic                res_q, res_d;
   logic [3:0]          value_q, value_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic [2:0]          bet_q, bet_d;
   logic [15:0]         win_q, win_d;
   logic [3:0]          rank_q [NUM_SLOTS];
   logic [3:0]          rank_d [NUM_SLOTS];
   logic [1:0]          suit_q [NUM_SLOTS];
   logic [1:0]          suit_d [NUM_SLOTS];

   logic                card_take;
   logic                deal_ok;
   logic [2:0]          next_slot;
   logic [15:0]         lut_win;
   logic [15:0]         credit_add;
   logic [2:0]          credit_sub;
   logic [SUM_W-1:0]    credit_sum;

   poker_payout_lut u_payout (
      .value_i (value_q),
      .bet_i   (bet_q),
      .win_o   (lut_win)
   );

   assign card_take = req_q & card_ack;
   assign deal_ok   = deal_btn && (SUM_W'(credits_q) >= SUM_W'(bet_q));
   assign next_slot = first_unheld(hold_q, idx_q + 3'd1);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      req_d      = req_q;
      res_d      = res_q;
      value_d    = value_q;
      bet_d      = bet_q;
      win_d      = win_q;
      rank_d     = rank_q;
      suit_d     = suit_q;
      credit_add = '0;
      credit_sub = '0;

      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (card_take && (idx_q == 3'(i))) begin
            rank_d[i] = card_rank;
            suit_d[i] = card_suit;
         end
      end
      // Every accepted card forces a one-cycle gap in card_req.
      if (card_take) req_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (deal_ok) begin
               state_d    = ST_DEAL;
               idx_d      = '0;
               win_d      = '0;
               req_d      = 1'b1;
               credit_sub = bet_q;
            end else if (bet_btn) begin
               bet_d = (bet_q == BET_MAX) ? 3'd1 : bet_q + 3'd1;
            end
         end
         ST_DEAL: begin
            if (card_take) begin
               if (idx_q == 3'd4) state_d = ST_HOLD;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (draw_btn) begin
               hold_d  = hold;
               idx_d   = first_unheld(hold, 3'd0);
               req_d   = (hold != '1);
               state_d = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (card_take) begin
               if (next_slot == NO_SLOT) begin
                  state_d = ST_RESOLVE;
                  res_d   = 1'b1;
               end else begin
                  idx_d = next_slot;
               end
            end else if (hold_q == '1) begin
               state_d = ST_RESOLVE;
               res_d   = 1'b1;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_RESOLVE: begin
            if (res_q && resolved) begin
               value_d = value;
               res_d   = 1'b0;
               state_d = ST_PAYOUT;
            end
         end
         ST_PAYOUT: begin
            win_d      = lut_win;
            credit_add = lut_win;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            res_d   = 1'b0;
         end
      endcase
   end

   // Coin, debit and payout fold into one sum so saturation is applied once.
   always_comb begin
      credit_sum = SUM_W'(credits_q) + SUM_W'(coin) + SUM_W'(credit_add) - SUM_W'(credit_sub);
      credits_d  = (credit_sum > CRED_MAX) ? credits_q | '1 : credit_sum[CREDIT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         hold_q    <= '0;
         req_q     <= 1'b0;
         res_q     <= 1'b0;
         value_q   <= '0;
         credits_q <= '0;
         bet_q     <= 3'd1;
         win_q     <= '0;
         rank_q    <= '{default: '0};
         suit_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         req_q     <= req_d;
         res_q     <= res_d;
         value_q   <= value_d;
         credits_q <= credits_d;
         bet_q     <= bet_d;
         win_q     <= win_d;
         rank_q    <= rank_d;
         suit_q    <= suit_d;
      end
   end

   assign card_req = req_q;
   assign resolve  = res_q;
   assign credits  = credits_q;
   assign bet      = bet_q;
   assign win      = win_q;
   assign state    = state_q;
   assign rank0    = rank_q[0];
   assign rank1    = rank_q[1];
   assign rank2    = rank_q[2];
   assign rank3    = rank_q[3];
   assign rank4    = rank_q[4];
   assign suit0    = suit_q[0];
   assign suit1    = suit_q[1];
   assign suit2    = suit_q[2];
   assign suit3    = suit_q[3];
   assign suit4    = suit_q[4];

endmodule

// File: tb/tb_poker_game_ctrl.sv
// Self-checking bench for poker_game_ctrl with deck/resolver responders and a hand scoreboard.
module tb_poker_game_ctrl;

   localparam int CW = 16;
   localparam logic [2:0] S_IDLE = 3'd0, S_DEAL = 3'd1, S_HOLD = 3'd2,
                          S_DRAW = 3'd3, S_RES  = 3'd4, S_PAY  = 3'd5;

   logic          clk = 1'b0;
   logic          reset, coin, bet_btn, deal_btn, draw_btn, card_ack, resolved;
   logic [4:0]    hold;
   logic [3:0]    card_rank, value;
   logic [1:0]    card_suit;
   logic          card_req, resolve;
   logic [3:0]    rank0, rank1, rank2, rank3, rank4;
   logic [1:0]    suit0, suit1, suit2, suit3, suit4;
   logic [CW-1:0] credits;
   logic [2:0]    bet, state;
   logic [15:0]   win;
   logic [3:0]    r_o [5];
   logic [1:0]    s_o [5];

   assign r_o[0] = rank0; assign r_o[1] = rank1; assign r_o[2] = rank2;
   assign r_o[3] = rank3; assign r_o[4] = rank4;
   assign s_o[0] = suit0; assign s_o[1] = suit1; assign s_o[2] = suit2;
   assign s_o[3] = suit3; assign s_o[4] = suit4;

   always #5 clk = ~clk;

   poker_game_ctrl #(.CREDIT_W(CW), .MAX_BET(5)) dut (
      .clk(clk), .reset(reset), .coin(coin), .bet_btn(bet_btn), .deal_btn(deal_btn),
      .hold(hold), .draw_btn(draw_btn), .card_req(card_req), .card_ack(card_ack),
      .card_rank(card_rank), .card_suit(card_suit),
      .rank0(rank0), .rank1(rank1), .rank2(rank2), .rank3(rank3), .rank4(rank4),
      .suit0(suit0), .suit1(suit1), .suit2(suit2), .suit3(suit3), .suit4(suit4),
      .resolve(resolve), .resolved(resolved), .value(value),
      .credits(credits), .bet(bet), .win(win), .state(state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- deck and resolver responders ----------------
   logic [3:0] deck_rank [32];
   logic [1:0] deck_suit [32];
   int         deck_ptr  = 0;
   int         req_rises = 0;
   int         ack_dly   = 0;
   int         res_dly   = 1;
   logic [3:0] res_value = 4'd0;
   logic       req_prev  = 1'b0;
   int         wcnt      = 0;
   int         rcnt      = 0;

   initial begin
      card_ack = 1'b0; card_rank = '0; card_suit = '0;
      forever begin
         tick();
         if (card_req === 1'b1 && !req_prev) req_rises++;
         req_prev = (card_req === 1'b1);
         if (card_ack) card_ack = 1'b0;
         else if (card_req === 1'b1) begin
            if (wcnt >= ack_dly) begin
               card_ack  = 1'b1;
               card_rank = deck_rank[deck_ptr % 32];
               card_suit = deck_suit[deck_ptr % 32];
               deck_ptr++;
               wcnt = 0;
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   initial begin
      resolved = 1'b0; value = '0;
      forever begin
         tick();
         if (resolved) resolved = 1'b0;
         else if (resolve === 1'b1) begin
            if (rcnt >= res_dly) begin
               resolved = 1'b1;
               value    = res_value;
               rcnt     = 0;
            end else rcnt++;
         end else rcnt = 0;
      end
   end

   // ---------------- scoreboard: one entry per hand, popped on PAYOUT->IDLE ----------------
   typedef struct {
      logic [15:0]   win;
      logic [CW-1:0] cred;
   } sb_t;
   sb_t        sb_q [$];
   sb_t        sb_e;
   logic [2:0] prev_state = 3'bx;

   initial begin
      forever begin
         tick();
         if (prev_state === S_PAY && state === S_IDLE) begin
            if (sb_q.size() == 0) check("sb_unexpected_hand", 32'd1, 32'd0);
            else begin
               sb_e = sb_q.pop_front();
               check("sb_win", 32'(win), 32'(sb_e.win));
               check("sb_credits", 32'(credits), 32'(sb_e.cred));
            end
         end
         prev_state = state;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      deck_ptr  = 0;
      req_rises = 0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(state), 32'(s));
   endtask

   task automatic add_coins(input int n);
      coin = 1'b1;
      repeat (n) tick();
      coin = 1'b0;
   endtask

   task automatic press_bet(input int n);
      repeat (n) begin
         bet_btn = 1'b1; tick(); bet_btn = 1'b0;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int            coins;
      int            presses;
      logic [4:0]    hmask;
      logic [3:0]    val;
      int            dly;
      logic [15:0]   exp_win;
      logic [CW-1:0] exp_cred;
      logic [2:0]    exp_bet;
      int            exp_reqs;
   } vec_t;

   vec_t       vecs [11];
   logic [3:0] er [5];
   logic [1:0] es [5];
   logic [2:0] bet_seq [5];
   int         p;
   logic       any_req;

   initial begin
      reset = 1'b1; coin = 1'b0; bet_btn = 1'b0; deal_btn = 1'b0;
      draw_btn = 1'b0; hold = '0;

      //          coins pr hold       val dly  win      credits  bet  reqs
      vecs[0]  = '{3,  0, 5'b11111, 4'd1,  0, 16'd1,    16'd3,    3'd1, 5};
      vecs[1]  = '{10, 4, 5'b11111, 4'd9,  0, 16'd1250, 16'd1255, 3'd5, 5};
      vecs[2]  = '{4,  1, 5'b10101, 4'd2,  3, 16'd4,    16'd6,    3'd2, 7};
      vecs[3]  = '{5,  2, 5'b00000, 4'd0,  0, 16'd0,    16'd2,    3'd3, 10};
      vecs[4]  = '{7,  3, 5'b01010, 4'd7,  1, 16'd100,  16'd103,  3'd4, 8};
      vecs[5]  = '{2,  0, 5'b11111, 4'd12, 0, 16'd0,    16'd1,    3'd1, 5};
      vecs[6]  = '{6,  5, 5'b10000, 4'd6,  2, 16'd9,    16'd14,   3'd1, 9};
      vecs[7]  = '{3,  2, 5'b11110, 4'd8,  0, 16'd150,  16'd150,  3'd3, 6};
      vecs[8]  = '{2,  1, 5'b11011, 4'd5,  0, 16'd12,   16'd12,   3'd2, 6};
      vecs[9]  = '{1,  0, 5'b00111, 4'd4,  1, 16'd4,    16'd4,    3'd1, 7};
      vecs[10] = '{9,  3, 5'b01111, 4'd3,  0, 16'd12,   16'd17,   3'd4, 6};
      bet_seq  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

      // Reset state
      do_reset();
      check("rst_state", 32'(state), 32'(S_IDLE));
      check("rst_credits", 32'(credits), 32'd0);
      check("rst_bet", 32'(bet), 32'd1);
      check("rst_win", 32'(win), 32'd0);
      check("rst_card_req", 32'(card_req), 32'd0);
      check("rst_resolve", 32'(resolve), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rst_rank%0d", i), 32'(r_o[i]), 32'd0);
         check($sformatf("rst_suit%0d", i), 32'(s_o[i]), 32'd0);
      end

      // Table-driven hands
      for (int v = 0; v < 11; v++) begin
         do_reset();
         ack_dly   = vecs[v].dly;
         res_value = vecs[v].val;
         for (int k = 0; k < 32; k++) begin
            deck_rank[k] = 4'((k * 5 + v * 3) % 13 + 1);
            deck_suit[k] = 2'((k + v) % 4);
         end
         add_coins(vecs[v].coins);
         press_bet(vecs[v].presses);
         check($sformatf("v%0d_bet", v), 32'(bet), 32'(vecs[v].exp_bet));
         sb_q.push_back('{win: vecs[v].exp_win, cred: vecs[v].exp_cred});
         deal_btn = 1'b1; tick(); deal_btn = 1'b0;
         check($sformatf("v%0d_deal_state", v), 32'(state), 32'(S_DEAL));
         check($sformatf("v%0d_debit", v), 32'(credits), 32'(vecs[v].coins - int'(vecs[v].exp_bet)));
         wait_state(S_HOLD, 400, $sformatf("v%0d_reach_hold", v));
         check($sformatf("v%0d_deal_acks", v), 32'(deck_ptr), 32'd5);
         hold = vecs[v].hmask;
         draw_btn = 1'b1; tick(); draw_btn = 1'b0;
         wait_state(S_IDLE, 400, $sformatf("v%0d_reach_idle", v));
         check($sformatf("v%0d_acks", v), 32'(deck_ptr), 32'(vecs[v].exp_reqs));
         check($sformatf("v%0d_req_rises", v), 32'(req_rises), 32'(vecs[v].exp_reqs));
         for (int i = 0; i < 5; i++) begin
            er[i] = deck_rank[i];
            es[i] = deck_suit[i];
         end
         p = 5;
         for (int i = 0; i < 5; i++) begin
            if (!vecs[v].hmask[i]) begin
               er[i] = deck_rank[p];
               es[i] = deck_suit[p];
               p++;
            end
         end
         for (int i = 0; i < 5; i++) begin
            check($sformatf("v%0d_rank%0d", v, i), 32'(r_o[i]), 32'(er[i]));
            check($sformatf("v%0d_suit%0d", v, i), 32'(s_o[i]), 32'(es[i]));
         end
      end

      // Deal refused with zero credits, and with credits below bet
      do_reset();
      ack_dly = 0;
      any_req = 1'b0;
      deal_btn = 1'b1; tick(); deal_btn = 1'b0;
      repeat (20) begin
         if (card_req !== 1'b0) any_req = 1'b1;
         tick();
      end
      check("nocred_state", 32'(state), 32'(S_IDLE));
      check("nocred_req", 32'(any_req), 32'd0);
      add_coins(1);
      press_bet(1);
      deal_btn = 1'b1; tick(); deal_btn = 1'b0;
      tick();
      check("lowcred_state", 32'(state), 32'(S_IDLE));
      check("lowcred_credits", 32'(credits), 32'd1);

      // Bet wraps at MAX_BET
      do_reset();
      for (int i = 0; i < 5; i++) begin
         press_bet(1);
         check($sformatf("betwrap_%0d", i), 32'(bet), 32'(bet_seq[i]));
      end

      // Coin landing on the deal debit cycle: net +1 -bet
      do_reset();
      add_coins(2);
      coin = 1'b1; deal_btn = 1'b1; tick(); coin = 1'b0; deal_btn = 1'b0;
      check("coin_deal_state", 32'(state), 32'(S_DEAL));
      check("coin_deal_credits", 32'(credits), 32'd2);

      // Reset mid-DRAW with card_req pending; bet_btn ignored outside IDLE
      do_reset();
      ack_dly = 0;
      add_coins(5);
      press_bet(2);
      deal_btn = 1'b1; tick(); deal_btn = 1'b0;
      wait_state(S_HOLD, 400, "midrst_reach_hold");
      press_bet(1);
      check("midrst_bet_locked", 32'(bet), 32'd3);
      ack_dly = 20;
      hold = 5'b00000;
      draw_btn = 1'b1; tick(); draw_btn = 1'b0;
      check("midrst_in_draw", 32'(state), 32'(S_DRAW));
      check("midrst_req_high", 32'(card_req), 32'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      check("midrst_state", 32'(state), 32'(S_IDLE));
      check("midrst_req", 32'(card_req), 32'd0);
      check("midrst_credits", 32'(credits), 32'd0);
      check("midrst_bet", 32'(bet), 32'd1);
      ack_dly = 0;

      // Saturation: royal flush near the ceiling plus coin in the PAYOUT cycle
      do_reset();
      res_value = 4'd9;
      add_coins(65534);
      check("sat_pre_credits", 32'(credits), 32'd65534);
      sb_q.push_back('{win: 16'd250, cred: 16'hFFFF});
      deal_btn = 1'b1; tick(); deal_btn = 1'b0;
      check("sat_debit", 32'(credits), 32'd65533);
      wait_state(S_HOLD, 400, "sat_reach_hold");
      hold = 5'b11111;
      draw_btn = 1'b1; tick(); draw_btn = 1'b0;
      wait_state(S_PAY, 400, "sat_reach_payout");
      coin = 1'b1; tick(); coin = 1'b0;
      check("sat_idle", 32'(state), 32'(S_IDLE));
      add_coins(1);
      check("sat_coin_hold", 32'(credits), 32'd65535);

      tick(); tick(); tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
